// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - fetch PC generator and IF/ID/EX hold/flush control for the 3-stage core
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   jump_en_i           EX stage requests a redirect this cycle
//   jump_addr_i         redirect target (low two bits are dropped, recorded in misalign_o)
//   hold_i              EX multi-cycle op: freeze the front end
//   hold_ext_i          fetch bus stall: PC/IF may not advance
//   pc_o                registered fetch address
//   hold_pc_o           PC register keeps its value
//   hold_if_id_o        IF/ID register keeps its contents
//   hold_id_ex_o        ID/EX register keeps its contents
//   flush_if_id_o       IF/ID loads a bubble
//   flush_id_ex_o       ID/EX loads a bubble
//   misalign_o          sticky flag: some accepted target was not word aligned
//   jump_cnt_o          saturating count of accepted redirects
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_i,
    input  logic             hold_ext_i,
    output logic [31:0]      pc_o,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] jump_cnt_o
);

    // Drain counter only needs to hold FLUSH_CYCLES-1.
    localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pend_q, pend_d;
    logic          mis_q;
    logic [CNT_W-1:0] jcnt_q;
    logic          accept;

    logic [31:0]   target;
    assign target = {jump_addr_i[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        accept        = 1'b0;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;

        case (state_q)
            PEND: begin
                // EX already holds a bubble; only the fetch stall matters here.
                flush_if_id_o = 1'b1;
                if (hold_ext_i) begin
                    hold_pc_o = 1'b1;
                end else begin
                    pc_d = pend_q;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_INIT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                // DRAIN behaves like RUN but keeps squashing the stale fetch data.
                if (state_q == DRAIN) begin
                    flush_if_id_o = 1'b1;
                    cnt_d         = cnt_q - DW'(1);
                    if (cnt_q == DW'(1)) begin
                        state_d = RUN;
                    end
                end
                if (jump_en_i && !hold_ext_i) begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    pc_d          = target;
                    accept        = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_INIT;
                    end else begin
                        state_d = RUN;
                    end
                end else if (jump_en_i) begin
                    // Fetch bus busy: park the target until the stall clears.
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    hold_pc_o     = 1'b1;
                    pend_d        = target;
                    accept        = 1'b1;
                    state_d       = PEND;
                end else if (hold_ext_i) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (hold_i) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
        endcase

        if (rst) begin
            hold_pc_o     = 1'b0;
            hold_if_id_o  = 1'b0;
            hold_id_ex_o  = 1'b0;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            mis_q   <= 1'b0;
            jcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            if (accept && (jump_addr_i[1:0] != 2'b00)) begin
                mis_q <= 1'b1;
            end
            if (accept && (jcnt_q != {CNT_W{1'b1}})) begin
                jcnt_q <= jcnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_o       = pc_q;
    assign misalign_o = mis_q;
    assign jump_cnt_o = jcnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jmp = 1'b0;
    logic [31:0] addr = '0;
    logic        hld = 1'b0;
    logic        ext = 1'b0;

    logic [31:0] o_pc  [3];
    logic        o_hpc [3];
    logic        o_hif [3];
    logic        o_hex [3];
    logic        o_fif [3];
    logic        o_fex [3];
    logic        o_mis [3];
    logic [31:0] o_cnt [3];
    logic [15:0] c0, c1;
    logic [1:0]  c2;

    assign o_cnt[0] = {16'b0, c0};
    assign o_cnt[1] = {16'b0, c1};
    assign o_cnt[2] = {30'b0, c2};

    always #5 clk = ~clk;

    pipe_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(1), .CNT_W(16)) d0 (
        .clk(clk), .rst(rst), .jump_en_i(jmp), .jump_addr_i(addr), .hold_i(hld), .hold_ext_i(ext),
        .pc_o(o_pc[0]), .hold_pc_o(o_hpc[0]), .hold_if_id_o(o_hif[0]), .hold_id_ex_o(o_hex[0]),
        .flush_if_id_o(o_fif[0]), .flush_id_ex_o(o_fex[0]), .misalign_o(o_mis[0]), .jump_cnt_o(c0));
    pipe_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(3), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .jump_en_i(jmp), .jump_addr_i(addr), .hold_i(hld), .hold_ext_i(ext),
        .pc_o(o_pc[1]), .hold_pc_o(o_hpc[1]), .hold_if_id_o(o_hif[1]), .hold_id_ex_o(o_hex[1]),
        .flush_if_id_o(o_fif[1]), .flush_id_ex_o(o_fex[1]), .misalign_o(o_mis[1]), .jump_cnt_o(c1));
    pipe_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(1), .CNT_W(2)) d2 (
        .clk(clk), .rst(rst), .jump_en_i(jmp), .jump_addr_i(addr), .hold_i(hld), .hold_ext_i(ext),
        .pc_o(o_pc[2]), .hold_pc_o(o_hpc[2]), .hold_if_id_o(o_hif[2]), .hold_id_ex_o(o_hex[2]),
        .flush_if_id_o(o_fif[2]), .flush_id_ex_o(o_fex[2]), .misalign_o(o_mis[2]), .jump_cnt_o(c2));

    int nchk = 0;
    int nerr = 0;

    // Model: per instance, the fetch PC, a parked target (if any), how many extra
    // squash cycles remain after a redirect, the sticky misalign flag and a raw redirect count.
    int          fcs  [3] = '{1, 3, 1};
    int          cmax [3] = '{65535, 65535, 3};
    logic [31:0] m_pc    [3];
    bit          m_pend  [3];
    logic [31:0] m_paddr [3];
    int          m_left  [3];
    bit          m_mis   [3];
    int          m_n     [3];
    bit          known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bit e_hpc, e_hif, e_hex, e_fif, e_fex;
            int nl;
            e_hpc = 0; e_hif = 0; e_hex = 0; e_fif = 0; e_fex = 0;
            nl = 0;
            if (rst) begin
                e_fif = 1; e_fex = 1;
            end else if (m_pend[k]) begin
                e_fif = 1;
                if (ext) e_hpc = 1;
            end else begin
                e_fif = (m_left[k] > 0);
                if (jmp) begin
                    e_fif = 1; e_fex = 1; e_hpc = ext;
                end else if (ext) begin
                    e_hpc = 1; e_hif = 1; e_fex = 1;
                end else if (hld) begin
                    e_hpc = 1; e_hif = 1; e_hex = 1;
                end
            end
            chk($sformatf("d%0d_hold_pc", k),    {31'b0, o_hpc[k]}, {31'b0, e_hpc});
            chk($sformatf("d%0d_hold_if_id", k), {31'b0, o_hif[k]}, {31'b0, e_hif});
            chk($sformatf("d%0d_hold_id_ex", k), {31'b0, o_hex[k]}, {31'b0, e_hex});
            chk($sformatf("d%0d_flush_if_id", k), {31'b0, o_fif[k]}, {31'b0, e_fif});
            chk($sformatf("d%0d_flush_id_ex", k), {31'b0, o_fex[k]}, {31'b0, e_fex});
            if (known) begin
                chk($sformatf("d%0d_pc", k), o_pc[k], m_pc[k]);
                chk($sformatf("d%0d_misalign", k), {31'b0, o_mis[k]}, {31'b0, m_mis[k]});
                chk($sformatf("d%0d_jump_cnt", k), o_cnt[k],
                    (m_n[k] > cmax[k]) ? cmax[k] : m_n[k]);
            end
            // advance model
            if (rst) begin
                m_pc[k] = 32'h0; m_pend[k] = 0; m_left[k] = 0; m_mis[k] = 0; m_n[k] = 0;
            end else if (m_pend[k]) begin
                if (!ext) begin
                    m_pc[k] = m_paddr[k]; m_pend[k] = 0; m_left[k] = fcs[k] - 1;
                end
            end else begin
                nl = (m_left[k] > 0) ? m_left[k] - 1 : 0;
                if (jmp) begin
                    m_n[k]++;
                    if (addr % 4 != 0) m_mis[k] = 1;
                    if (ext) begin
                        m_pend[k] = 1; m_paddr[k] = addr & ~32'd3; nl = 0;
                    end else begin
                        m_pc[k] = addr & ~32'd3; nl = fcs[k] - 1;
                    end
                end else if (!ext && !hld) begin
                    m_pc[k] = m_pc[k] + 32'd4;
                end
                m_left[k] = nl;
            end
        end
        if (rst) known = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit j, input logic [31:0] a, input bit h, input bit e);
        rst = r; jmp = j; addr = a; hld = h; ext = e;
        step();
    endtask

    initial begin
        // 1: reset, then free-running fetch
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("t1_pc_reset", o_pc[0], 32'h0);
        chk("t1_cnt_reset", o_cnt[0], 32'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0);
            chk("t1_pc_seq", o_pc[0], 32'(i * 4));
        end
        // 2: single redirect
        drive(0, 1, 32'h100, 0, 0);
        chk("t2_pc_target", o_pc[0], 32'h100);
        chk("t2_cnt", o_cnt[0], 32'd1);
        drive(0, 0, 0, 0, 0);
        chk("t2_pc_next", o_pc[0], 32'h104);
        // 3: EX hold freezes the front end
        drive(0, 1, 32'h20, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("t3_pc_held", o_pc[0], 32'h20);
        end
        drive(0, 0, 0, 0, 0);
        chk("t3_pc_after", o_pc[0], 32'h24);
        // 4: redirect during fetch stall is parked, counted once
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 32'h200, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 32'h300, 1, 1);
        chk("t4_pc_pend", o_pc[0], 32'h0);
        drive(0, 0, 0, 0, 0);
        chk("t4_pc_release", o_pc[0], 32'h200);
        chk("t4_cnt_once", o_cnt[0], 32'd1);
        // 5: misaligned target, long drain on d1
        drive(0, 1, 32'h103, 0, 0);
        chk("t5_pc_aligned", o_pc[0], 32'h100);
        chk("t5_misalign", {31'b0, o_mis[0]}, 32'd1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        chk("t5_misalign_sticky", {31'b0, o_mis[1]}, 32'd1);
        // 6: narrow counter saturation and PC wrap
        drive(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 32'(i * 64), 0, 0);
            chk("t6_cnt_sat", o_cnt[2], (i > 3) ? 32'd3 : 32'(i));
        end
        drive(0, 1, 32'hFFFF_FFFC, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("t6_pc_wrap", o_pc[0], 32'h0);
        // Random traffic, including resets mid-drain / mid-pend
        for (int i = 0; i < 800; i++) begin
            bit r, j, h, e;
            logic [31:0] a;
            r = ($urandom_range(0, 99) < 2);
            j = ($urandom_range(0, 99) < 20);
            h = ($urandom_range(0, 99) < 20);
            e = ($urandom_range(0, 99) < 25);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            drive(r, j, a, h, e);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
